// File: rtl/bw_pkg.sv
// Shared definitions for the Baugh-Wooley arithmetic blocks: FSM states,
// default operand width and a counter-width helper.
package bw_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIX
    } state_t;

    localparam int BW_N = 5;

    // Minimum bit width able to hold the values 0..n-1 (never less than 1).
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/bw_seq_divider_twos_negate.sv
// Conditional two's-complement negation; shared by the divider for operand
// magnitudes and for the final sign fix.
module twos_negate #(
    parameter int n = 5
) (
    input  logic [n-1:0] x,
    input  logic         neg,
    output logic [n-1:0] y
);

    assign y = neg ? (-x) : x;

endmodule

// File: rtl/bw_seq_divider.sv
// Sequential signed restoring divider, one quotient bit per cycle, n+2 cycles
// per result. Optional macro BW_DIV_SAT_OVF_EN saturates -2^(n-1)/-1 and adds ovf_out.
module bw_seq_divider
    import bw_pkg::*;
#(
    parameter int n = BW_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_in,
    input  logic [n-1:0] a_in,
    input  logic [n-1:0] b_in,
    output logic         busy_out,
    output logic         done_out,
    output logic [n-1:0] q_out,
    output logic [n-1:0] r_out,
`ifdef BW_DIV_SAT_OVF_EN
    output logic         ovf_out,
`endif
    output logic         dz_out
);

    localparam int CW = clog2(n);

    state_t        state, state_next;
    logic [n-1:0]  a_sh;
    logic [n-1:0]  b_mag;
    logic [n-1:0]  q_mag;
    logic [n-1:0]  r_mag;
    logic          sign_a, sign_b, zero_b;
    logic [CW-1:0] cnt;

    logic [n-1:0]  a_abs, b_abs, q_fix, r_fix;
    logic [n:0]    pr_shift;
    logic [n-1:0]  pr_diff;
    logic          pr_ge;

    twos_negate #(.n(n)) u_neg_a (.x(a_in),  .neg(a_in[n-1]),     .y(a_abs));
    twos_negate #(.n(n)) u_neg_b (.x(b_in),  .neg(b_in[n-1]),     .y(b_abs));
    twos_negate #(.n(n)) u_neg_q (.x(q_mag), .neg(sign_a ^ sign_b), .y(q_fix));
    twos_negate #(.n(n)) u_neg_r (.x(r_mag), .neg(sign_a),        .y(r_fix));

    // The partial remainder stays below |b| <= 2^(n-1), so only the shifted
    // value needs the extra bit; the difference always fits in n bits.
    assign pr_shift = {r_mag, a_sh[n-1]};
    assign pr_ge    = (pr_shift >= {1'b0, b_mag});
    assign pr_diff  = pr_shift[n-1:0] - b_mag;

    assign busy_out = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_in) state_next = DIV;
            DIV:     if (cnt == '0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh     <= '0;
            b_mag    <= '0;
            q_mag    <= '0;
            r_mag    <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            zero_b   <= 1'b0;
            cnt      <= '0;
            done_out <= 1'b0;
            q_out    <= '0;
            r_out    <= '0;
            dz_out   <= 1'b0;
`ifdef BW_DIV_SAT_OVF_EN
            ovf_out  <= 1'b0;
`endif
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        a_sh   <= a_abs;
                        b_mag  <= b_abs;
                        sign_a <= a_in[n-1];
                        sign_b <= b_in[n-1];
                        zero_b <= (b_in == '0);
                        q_mag  <= '0;
                        r_mag  <= '0;
                        cnt    <= CW'(n - 1);
                    end
                end
                DIV: begin
                    a_sh  <= a_sh << 1;
                    r_mag <= pr_ge ? pr_diff : pr_shift[n-1:0];
                    q_mag <= {q_mag[n-2:0], pr_ge};
                    cnt   <= cnt - CW'(1);
                end
                FIX: begin
                    done_out <= 1'b1;
                    dz_out   <= zero_b;
`ifdef BW_DIV_SAT_OVF_EN
                    ovf_out  <= 1'b0;
`endif
                    // With b=0 every step subtracts nothing, so r_mag ends as |a|
                    // and the sign fix reproduces the original dividend.
                    if (zero_b) begin
                        q_out <= '1;
                        r_out <= r_fix;
`ifdef BW_DIV_SAT_OVF_EN
                    end else if (sign_a && sign_b && q_mag == {1'b1, {(n-1){1'b0}}}) begin
                        q_out   <= {1'b0, {(n-1){1'b1}}};
                        r_out   <= '0;
                        ovf_out <= 1'b1;
`endif
                    end else begin
                        q_out <= q_fix;
                        r_out <= r_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bw_seq_divider.sv
// Scoreboard bench for bw_seq_divider: directed cases plus random operands
// checked against an integer-arithmetic reference model.
module tb_bw_seq_divider;

    localparam int N = 5;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        logic         ovf;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_in = 1'b0;
    logic [N-1:0] a_in = '0;
    logic [N-1:0] b_in = '0;
    logic         busy_out, done_out, dz_out;
    logic [N-1:0] q_out, r_out;
`ifdef BW_DIV_SAT_OVF_EN
    logic         ovf_out;
`endif

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    bw_seq_divider #(.n(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_in (start_in),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy_out (busy_out),
        .done_out (done_out),
        .q_out    (q_out),
        .r_out    (r_out),
`ifdef BW_DIV_SAT_OVF_EN
        .ovf_out  (ovf_out),
`endif
        .dz_out   (dz_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference model: plain signed integer division truncating toward zero.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        int   sa, sb, qi, ri;
        sa = int'($signed(a));
        sb = int'($signed(b));
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        e.due = 0;
        if (sb == 0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else if (sa == -(1 << (N-1)) && sb == -1) begin
`ifdef BW_DIV_SAT_OVF_EN
            qi    = (1 << (N-1)) - 1;
            e.ovf = 1'b1;
`else
            qi = 1 << (N-1);
`endif
            e.q = qi[N-1:0];
            e.r = '0;
        end else begin
            qi  = sa / sb;
            ri  = sa % sb;
            e.q = qi[N-1:0];
            e.r = ri[N-1:0];
        end
        return e;
    endfunction

    // Issues one start pulse; returns at the negedge after acceptance.
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        @(negedge clk);
        a_in     = a;
        b_in     = b;
        start_in = 1'b1;
        @(posedge clk);
        #1;
        e     = model(a, b);
        e.due = cyc + N + 1;
        exp_q.push_back(e);
        @(negedge clk);
        start_in = 1'b0;
        checkOutput("busy_after_start", int'(busy_out), 1);
    endtask

    task automatic waitDone();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_busy"}, int'(busy_out), 0);
        checkOutput({tag, "_done"}, int'(done_out), 0);
        checkOutput({tag, "_q"}, int'(q_out), 0);
        checkOutput({tag, "_r"}, int'(r_out), 0);
        checkOutput({tag, "_dz"}, int'(dz_out), 0);
`ifdef BW_DIV_SAT_OVF_EN
        checkOutput({tag, "_ovf"}, int'(ovf_out), 0);
`endif
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && done_out) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("latency", cyc, e.due);
                checkOutput("q", int'(q_out), int'(e.q));
                checkOutput("r", int'(r_out), int'(e.r));
                checkOutput("dz", int'(dz_out), int'(e.dz));
`ifdef BW_DIV_SAT_OVF_EN
                checkOutput("ovf", int'(ovf_out), int'(e.ovf));
`endif
                checkOutput("busy_in_done", int'(busy_out), 0);
            end
        end
    end

    initial begin
        logic [N-1:0] ra, rb;
        $display("[TB] starting bw_seq_divider bench, n=%0d", N);
        repeat (3) @(negedge clk);
        checkCleared("reset");
        rst = 1'b0;

        applyStimulus(5'd13, 5'd3);       waitDone();
        applyStimulus(5'b10011, 5'd3);    waitDone();
        applyStimulus(5'd13, 5'b11101);   waitDone();
        applyStimulus(5'd7, 5'd0);        waitDone();
        applyStimulus(5'b10000, 5'b11111); waitDone();
        applyStimulus(5'b10000, 5'd1);    waitDone();
        applyStimulus(5'b10000, 5'b10000); waitDone();
        applyStimulus(5'd15, 5'b10000);   waitDone();
        applyStimulus(5'b10000, 5'd0);    waitDone();

        // Start pulse while busy must be ignored.
        applyStimulus(5'd15, 5'd2);
        @(negedge clk);
        a_in = 5'd1; b_in = 5'd1; start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        waitDone();
        repeat (10) @(negedge clk);

        // Reset on the third DIV cycle aborts without a done pulse.
        applyStimulus(5'd9, 5'd4);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        checkCleared("abort");
        repeat (12) @(negedge clk);
        checkCleared("abort_idle");
        applyStimulus(5'd9, 5'd4);        waitDone();

        for (int i = 0; i < 40; i++) begin
            ra = N'($urandom_range(0, (1 << N) - 1));
            rb = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(0, (1 << N) - 1));
            applyStimulus(ra, rb);
            waitDone();
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
